// File: rtl/cl_conveyer_tap.sv
// cl_conveyer_tap: store-and-forward job buffer between a conveyer low-priority port and a
// local PairHMM worker. Escape mode cut-through drains jobs that cannot fit in the buffer.
module cl_conveyer_tap #(
  parameter type         T         = logic [7:0],
  parameter int unsigned DEPTH     = 16,
  parameter bit          STORE_FWD = 1'b1
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  T                         in_tdata,
  input  logic                     in_tlast,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  output T                         out_tdata,
  output logic                     out_tlast,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   jobs_o,
  output logic                     oversize_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [0:0] {
    IDLE_ST  = 1'b0,
    DRAIN_ST = 1'b1
  } state_e;

  T              mem_data_r [DEPTH];
  logic          mem_last_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [AW:0]   jobs_r;
  logic          oversize_r;
  state_e        state_r;
  state_e        state_nxt_s;
  logic          wr_s;
  logic          rd_s;
  logic          drain_s;

  // Ready looks only at the registered level, so there is no path from out_tready.
  assign in_tready  = (level_r != FULL_CNT);
  assign wr_s       = in_tvalid && in_tready;
  assign rd_s       = out_tvalid && out_tready;
  assign drain_s    = (state_r == DRAIN_ST);
  assign out_tdata  = mem_data_r[rd_ptr_r];
  assign out_tlast  = mem_last_r[rd_ptr_r];
  assign level_o    = level_r;
  assign jobs_o     = jobs_r;
  assign oversize_o = oversize_r;

  // Presentation gate: a job is offered only once its tlast word is held, unless draining.
  always_comb begin
    if (STORE_FWD) begin
      out_tvalid = (level_r != ZERO_CNT) && ((jobs_r != ZERO_CNT) || drain_s);
    end else begin
      out_tvalid = (level_r != ZERO_CNT);
    end
  end

  // Escape FSM: a full buffer holding no complete job can never present, so cut through.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE_ST: begin
        if (STORE_FWD && (level_r == FULL_CNT) && (jobs_r == ZERO_CNT)) begin
          state_nxt_s = DRAIN_ST;
        end else begin
          state_nxt_s = IDLE_ST;
        end
      end
      DRAIN_ST: begin
        if (rd_s && out_tlast) begin
          state_nxt_s = IDLE_ST;
        end else begin
          state_nxt_s = DRAIN_ST;
        end
      end
      default: state_nxt_s = IDLE_ST;
    endcase
  end

  // Storage write port; entries outside [rd_ptr, rd_ptr+level) are never observed.
  always_ff @(posedge clock_i) begin
    if (wr_s) begin
      mem_data_r[wr_ptr_r] <= in_tdata;
      mem_last_r[wr_ptr_r] <= in_tlast;
    end
  end

  // Pointers, occupancy/job counters, FSM state and sticky oversize flag.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= ZERO_CNT;
      jobs_r     <= ZERO_CNT;
      state_r    <= IDLE_ST;
      oversize_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (wr_s && !rd_s) begin
        level_r <= level_r + CNT_ONE;
      end else if (rd_s && !wr_s) begin
        level_r <= level_r - CNT_ONE;
      end
      if ((wr_s && in_tlast) && !(rd_s && out_tlast)) begin
        jobs_r <= jobs_r + CNT_ONE;
      end else if ((rd_s && out_tlast) && !(wr_s && in_tlast)) begin
        jobs_r <= jobs_r - CNT_ONE;
      end
      state_r <= state_nxt_s;
      if ((state_r == IDLE_ST) && (state_nxt_s == DRAIN_ST)) begin
        oversize_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cl_conveyer_tap.sv
// Directed self-checking bench for cl_conveyer_tap: store-and-forward instance (DEPTH=16)
// plus a plain-FIFO instance (DEPTH=4, STORE_FWD=0).
module tb_cl_conveyer_tap;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_tdata;
  logic       in_tlast, in_tvalid, in_tready;
  logic [7:0] out_tdata;
  logic       out_tlast, out_tvalid, out_tready;
  logic [4:0] level, jobs;
  logic       oversize;

  logic [7:0] pf_in_tdata;
  logic       pf_in_tlast, pf_in_tvalid, pf_in_tready;
  logic [7:0] pf_out_tdata;
  logic       pf_out_tlast, pf_out_tvalid, pf_out_tready;
  logic [2:0] pf_level, pf_jobs;
  logic       pf_oversize;

  int n_chk;
  int n_pass;

  cl_conveyer_tap #(.T(logic [7:0]), .DEPTH(16), .STORE_FWD(1'b1)) u_dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .level_o(level), .jobs_o(jobs), .oversize_o(oversize)
  );

  cl_conveyer_tap #(.T(logic [7:0]), .DEPTH(4), .STORE_FWD(1'b0)) u_pf (
    .clock_i(clk), .reset_n_i(rst_n),
    .in_tdata(pf_in_tdata), .in_tlast(pf_in_tlast), .in_tvalid(pf_in_tvalid),
    .in_tready(pf_in_tready), .out_tdata(pf_out_tdata), .out_tlast(pf_out_tlast),
    .out_tvalid(pf_out_tvalid), .out_tready(pf_out_tready), .level_o(pf_level),
    .jobs_o(pf_jobs), .oversize_o(pf_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = l;
    tick();
  endtask

  task automatic do_reset();
    in_tvalid  = 1'b0;
    in_tdata   = 8'h00;
    in_tlast   = 1'b0;
    out_tready = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    pf_in_tdata = 8'h00;
    pf_in_tlast = 1'b0;
    pf_in_tvalid = 1'b0;
    pf_out_tready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_valid", 32'(out_tvalid), 32'd0);
    chk("rst_ready", 32'(in_tready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_jobs", 32'(jobs), 32'd0);
    chk("rst_oversize", 32'(oversize), 32'd0);

    // 1) Three-word job held back until tlast is buffered
    out_tready = 1'b1;
    push(8'hA1, 1'b0);
    chk("t1_gate1", 32'(out_tvalid), 32'd0);
    chk("t1_level1", 32'(level), 32'd1);
    push(8'hA2, 1'b0);
    chk("t1_gate2", 32'(out_tvalid), 32'd0);
    push(8'hA3, 1'b1);
    in_tvalid = 1'b0;
    chk("t1_valid", 32'(out_tvalid), 32'd1);
    chk("t1_jobs", 32'(jobs), 32'd1);
    chk("t1_level3", 32'(level), 32'd3);
    chk("t1_d1", 32'(out_tdata), 32'hA1);
    tick();
    chk("t1_d2", 32'(out_tdata), 32'hA2);
    chk("t1_level2", 32'(level), 32'd2);
    tick();
    chk("t1_d3", 32'(out_tdata), 32'hA3);
    chk("t1_last3", 32'(out_tlast), 32'd1);
    tick();
    chk("t1_empty_valid", 32'(out_tvalid), 32'd0);
    chk("t1_empty_level", 32'(level), 32'd0);
    chk("t1_empty_jobs", 32'(jobs), 32'd0);

    // 2) Oversize job: fill with no tlast, escape into drain mode
    out_tready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
    in_tvalid = 1'b0;
    chk("t2_full_ready", 32'(in_tready), 32'd0);
    chk("t2_full_level", 32'(level), 32'd16);
    tick();
    chk("t2_oversize", 32'(oversize), 32'd1);
    chk("t2_valid", 32'(out_tvalid), 32'd1);
    out_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_valid", 32'(out_tvalid), 32'd1);
      chk("t2_drain_data", 32'(out_tdata), 32'(8'h10 + i));
      tick();
    end
    chk("t2_drained_level", 32'(level), 32'd0);
    push(8'h5A, 1'b1);
    in_tvalid = 1'b0;
    chk("t2_tail_valid", 32'(out_tvalid), 32'd1);
    chk("t2_tail_data", 32'(out_tdata), 32'h5A);
    chk("t2_tail_last", 32'(out_tlast), 32'd1);
    tick();
    chk("t2_tail_level", 32'(level), 32'd0);
    chk("t2_sticky", 32'(oversize), 32'd1);
    push(8'h77, 1'b0);
    in_tvalid = 1'b0;
    chk("t2_idle_gate", 32'(out_tvalid), 32'd0);
    chk("t2_idle_level", 32'(level), 32'd1);
    push(8'h78, 1'b1);
    in_tvalid = 1'b0;
    chk("t2_idle_d1", 32'(out_tdata), 32'h77);
    tick();
    chk("t2_idle_d2", 32'(out_tdata), 32'h78);
    tick();
    chk("t2_idle_empty", 32'(out_tvalid), 32'd0);

    // 3) Full with two jobs, out_tready toggling while upstream keeps pushing
    do_reset();
    chk("t3_rst_oversize", 32'(oversize), 32'd0);
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i), (i == 7) || (i == 15));
    chk("t3_full_jobs", 32'(jobs), 32'd2);
    for (int k = 0; k < 8; k++) begin
      chk("t3_ready_full", 32'(in_tready), 32'd0);
      chk("t3_level_full", 32'(level), 32'd16);
      chk("t3_rd_data", 32'(out_tdata), 32'(8'h30 + k));
      out_tready = 1'b1;
      in_tvalid  = 1'b1;
      in_tdata   = 8'(8'h40 + k);
      in_tlast   = (k == 7);
      tick();
      chk("t3_ready_after_rd", 32'(in_tready), 32'd1);
      chk("t3_level_after_rd", 32'(level), 32'd15);
      out_tready = 1'b0;
      tick();
    end
    in_tvalid  = 1'b0;
    chk("t3_oversize", 32'(oversize), 32'd0);
    chk("t3_jobs", 32'(jobs), 32'd2);
    out_tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("t3_order", 32'(out_tdata), (j < 8) ? 32'(8'h38 + j) : 32'(8'h40 + j - 8));
      tick();
    end
    chk("t3_end_level", 32'(level), 32'd0);
    chk("t3_end_jobs", 32'(jobs), 32'd0);

    // 4) Simultaneous tlast read and tlast write at jobs_o == 1
    out_tready = 1'b0;
    push(8'hB1, 1'b1);
    chk("t4_jobs_pre", 32'(jobs), 32'd1);
    out_tready = 1'b1;
    push(8'hB2, 1'b1);
    in_tvalid = 1'b0;
    chk("t4_jobs", 32'(jobs), 32'd1);
    chk("t4_level", 32'(level), 32'd1);
    chk("t4_data", 32'(out_tdata), 32'hB2);
    tick();
    chk("t4_empty", 32'(level), 32'd0);

    // 5) Asynchronous reset mid-job
    out_tready = 1'b0;
    push(8'hC0, 1'b0);
    push(8'hC1, 1'b1);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    push(8'hC4, 1'b0);
    in_tvalid = 1'b0;
    chk("t5_level5", 32'(level), 32'd5);
    chk("t5_valid_pre", 32'(out_tvalid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_tvalid), 32'd0);
    chk("t5_async_level", 32'(level), 32'd0);
    chk("t5_async_jobs", 32'(jobs), 32'd0);
    chk("t5_async_ready", 32'(in_tready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    out_tready = 1'b1;
    push(8'hD1, 1'b1);
    in_tvalid = 1'b0;
    chk("t5_new_valid", 32'(out_tvalid), 32'd1);
    chk("t5_new_data", 32'(out_tdata), 32'hD1);
    chk("t5_new_level", 32'(level), 32'd1);
    tick();
    chk("t5_new_empty", 32'(out_tvalid), 32'd0);

    // 6) Plain FIFO instance: no gating, never oversize
    pf_in_tvalid = 1'b1;
    pf_in_tdata  = 8'hE1;
    pf_in_tlast  = 1'b0;
    tick();
    pf_in_tvalid = 1'b0;
    chk("t6_valid", 32'(pf_out_tvalid), 32'd1);
    chk("t6_data", 32'(pf_out_tdata), 32'hE1);
    chk("t6_level", 32'(pf_level), 32'd1);
    pf_in_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pf_in_tdata = 8'(8'hE2 + i);
      tick();
    end
    pf_in_tvalid = 1'b0;
    tick();
    chk("t6_full_ready", 32'(pf_in_tready), 32'd0);
    chk("t6_full_level", 32'(pf_level), 32'd4);
    chk("t6_oversize", 32'(pf_oversize), 32'd0);
    chk("t6_head", 32'(pf_out_tdata), 32'hE1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
